// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the F-bus / M-bus to X-bus arbiter: widths, owner
// codes, the X-bus request payload and the round-robin pick helper.
package bus_arbiter_pkg;

    localparam int unsigned F_ADR_W = 62;
    localparam int unsigned F_DAT_W = 32;
    localparam int unsigned X_ADR_W = 61;
    localparam int unsigned X_DAT_W = 64;
    localparam int unsigned X_SEL_W = 8;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_F    = 2'd1;
    localparam logic [1:0] OWNER_M    = 2'd2;

    localparam logic LAST_F = 1'b0;
    localparam logic LAST_M = 1'b1;

    typedef struct packed {
        logic               cyc;
        logic               we;
        logic [X_ADR_W-1:0] adr;
        logic [X_SEL_W-1:0] sel;
        logic [X_DAT_W-1:0] dat;
    } xbus_req_t;

    // A 32-bit fetch occupies one half of the 64-bit X-bus word.
    function automatic logic [X_SEL_W-1:0] fetch_sel(input logic hi_word);
        return hi_word ? 8'hF0 : 8'h0F;
    endfunction

    // Round-robin pick when nobody holds the bus; on a tie the port that did not go last wins.
    function automatic logic [1:0] rr_pick(input logic f_req, input logic m_req, input logic last);
        if (f_req && m_req) begin
            return (last == LAST_F) ? OWNER_M : OWNER_F;
        end
        if (f_req) begin
            return OWNER_F;
        end
        if (m_req) begin
            return OWNER_M;
        end
        return OWNER_NONE;
    endfunction

endpackage

// File: rtl/bus_arbiter_timeout_counter.sv
// Watchdog for a stalled X-bus cycle; only built when BUS_TIMEOUT_EN is defined.
// Counts consecutive wait cycles and flags expiry on the last permitted one.
`ifdef BUS_TIMEOUT_EN
module bus_arbiter_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_wait,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign o_expire_c = i_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Any non-wait cycle (ack, idle, abandon) restarts the count for the next grant.
    always_comb begin
        w_cnt_nxt = '0;
        if (i_wait && !o_expire_c) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Shares the X-bus between instruction fetch (F) and data (M) ports with
// round-robin, zero-latency grant. Optional watchdog: BUS_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               f_cyc_i,
    input  logic [F_ADR_W-1:0] f_adr_i,
    output logic [F_DAT_W-1:0] f_dat_o,
    output logic               f_ack_o,
    output logic               f_err_o,

    input  logic               m_cyc_i,
    input  logic               m_we_i,
    input  logic [X_ADR_W-1:0] m_adr_i,
    input  logic [X_SEL_W-1:0] m_sel_i,
    input  logic [X_DAT_W-1:0] m_dat_i,
    output logic [X_DAT_W-1:0] m_dat_o,
    output logic               m_ack_o,
    output logic               m_err_o,

    output logic               x_cyc_o,
    output logic               x_we_o,
    output logic [X_ADR_W-1:0] x_adr_o,
    output logic [X_SEL_W-1:0] x_sel_o,
    output logic [X_DAT_W-1:0] x_dat_o,
    input  logic [X_DAT_W-1:0] x_dat_i,
    input  logic               x_ack_i
);

    logic [1:0] r_owner;
    logic       r_last;
    logic [1:0] w_owner_nxt;
    logic       w_last_nxt;
    logic [1:0] w_cur;
    xbus_req_t  w_req;
    logic       w_done;
    logic       w_wait;
    logic       w_expire;

    // A locked grant wins; otherwise arbitrate this cycle. Reset forces the bus idle.
    always_comb begin
        w_cur = OWNER_NONE;
        if (!reset_i) begin
            if (r_owner != OWNER_NONE) begin
                w_cur = r_owner;
            end else begin
                w_cur = rr_pick(f_cyc_i, m_cyc_i, r_last);
            end
        end
    end

    always_comb begin
        w_req = '0;
        case (w_cur)
            OWNER_F: begin
                w_req.cyc = f_cyc_i;
                w_req.adr = f_adr_i[F_ADR_W-1:1];
                w_req.sel = fetch_sel(f_adr_i[0]);
            end
            OWNER_M: begin
                w_req.cyc = m_cyc_i;
                w_req.we  = m_we_i;
                w_req.adr = m_adr_i;
                w_req.sel = m_sel_i;
                w_req.dat = m_dat_i;
            end
            default: ;
        endcase
    end

    assign x_cyc_o = w_req.cyc;
    assign x_we_o  = w_req.we;
    assign x_adr_o = w_req.adr;
    assign x_sel_o = w_req.sel;
    assign x_dat_o = w_req.dat;

    assign w_done = w_req.cyc && x_ack_i;
    assign w_wait = w_req.cyc && !x_ack_i;

    assign f_dat_o = f_adr_i[0] ? x_dat_i[X_DAT_W-1:F_DAT_W] : x_dat_i[F_DAT_W-1:0];
    assign m_dat_o = x_dat_i;
    assign f_ack_o = w_done && (w_cur == OWNER_F);
    assign m_ack_o = w_done && (w_cur == OWNER_M);
    assign f_err_o = w_expire && (w_cur == OWNER_F);
    assign m_err_o = w_expire && (w_cur == OWNER_M);

`ifdef BUS_TIMEOUT_EN
    bus_arbiter_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .i_wait     (w_wait),
        .o_expire_c (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = w_wait || (TIMEOUT_CYCLES == 32'd0);
    assign w_expire         = 1'b0;
`endif

    // Completion or watchdog releases the bus; a wait state locks it; a dropped request releases it.
    always_comb begin
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        if (w_done || w_expire) begin
            w_owner_nxt = OWNER_NONE;
            w_last_nxt  = (w_cur == OWNER_M) ? LAST_M : LAST_F;
        end else if (w_req.cyc) begin
            w_owner_nxt = w_cur;
        end else begin
            w_owner_nxt = OWNER_NONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_owner <= OWNER_NONE;
            r_last  <= LAST_F;
        end else begin
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed table of cycles, then randomized traffic
// checked against a port-level reference model. Honours BUS_TIMEOUT_EN.
module tb_bus_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        f_cyc_i;
    logic [61:0] f_adr_i;
    logic [31:0] f_dat_o;
    logic        f_ack_o, f_err_o;
    logic        m_cyc_i, m_we_i;
    logic [60:0] m_adr_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_dat_i, m_dat_o;
    logic        m_ack_o, m_err_o;
    logic        x_cyc_o, x_we_o;
    logic [60:0] x_adr_o;
    logic [7:0]  x_sel_o;
    logic [63:0] x_dat_o, x_dat_i;
    logic        x_ack_i;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .f_cyc_i(f_cyc_i), .f_adr_i(f_adr_i), .f_dat_o(f_dat_o),
        .f_ack_o(f_ack_o), .f_err_o(f_err_o),
        .m_cyc_i(m_cyc_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i),
        .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .x_cyc_o(x_cyc_o), .x_we_o(x_we_o), .x_adr_o(x_adr_o), .x_sel_o(x_sel_o),
        .x_dat_o(x_dat_o), .x_dat_i(x_dat_i), .x_ack_i(x_ack_i)
    );

    typedef struct packed {
        logic        x_cyc;
        logic        x_we;
        logic [60:0] x_adr;
        logic [7:0]  x_sel;
        logic [63:0] x_dat;
        logic        f_ack;
        logic        f_err;
        logic        m_ack;
        logic        m_err;
        logic [31:0] f_dat;
        logic [63:0] m_dat;
    } out_t;

    typedef struct {
        logic        rst;
        logic        f_cyc;
        logic [63:0] f_byte;
        logic        m_cyc;
        logic        m_we;
        logic [60:0] m_adr;
        logic [7:0]  m_sel;
        logic [63:0] m_dat;
        logic [63:0] x_dat;
        logic        x_ack;
        out_t        exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    // Expected port values when port 'cur' (0 none, 1 fetch, 2 data) owns the bus this cycle.
    function automatic out_t model_out(input vec_t v, input int cur, input logic err);
        out_t o;
        int   lane;
        o       = '0;
        lane    = int'((v.f_byte >> 2) & 64'd1);
        o.f_dat = 32'(v.x_dat >> (32 * lane));
        o.m_dat = v.x_dat;
        if (cur == 1) begin
            o.x_cyc = v.f_cyc;
            o.x_adr = 61'(v.f_byte >> 3);
            o.x_sel = (lane == 1) ? 8'hF0 : 8'h0F;
            o.f_ack = v.f_cyc && v.x_ack && !err;
            o.f_err = err;
        end else if (cur == 2) begin
            o.x_cyc = v.m_cyc;
            o.x_we  = v.m_we;
            o.x_adr = v.m_adr;
            o.x_sel = v.m_sel;
            o.x_dat = v.m_dat;
            o.m_ack = v.m_cyc && v.x_ack && !err;
            o.m_err = err;
        end
        return o;
    endfunction

    function automatic vec_t row(input logic rst, input logic f, input logic [63:0] fb,
                                 input logic m, input logic we, input logic [60:0] ma,
                                 input logic [7:0] sel, input logic [63:0] md,
                                 input logic [63:0] xd, input logic ack,
                                 input int cur, input logic err);
        vec_t v;
        v.rst = rst; v.f_cyc = f; v.f_byte = fb; v.m_cyc = m; v.m_we = we;
        v.m_adr = ma; v.m_sel = sel; v.m_dat = md; v.x_dat = xd; v.x_ack = ack;
        v.exp = model_out(v, cur, err);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset_i = v.rst;
        f_cyc_i = v.f_cyc;
        f_adr_i = 62'(v.f_byte >> 2);
        m_cyc_i = v.m_cyc;
        m_we_i  = v.m_we;
        m_adr_i = v.m_adr;
        m_sel_i = v.m_sel;
        m_dat_i = v.m_dat;
        x_dat_i = v.x_dat;
        x_ack_i = v.x_ack;
    endtask

    task automatic check(input out_t exp, input string tag, input int idx);
        out_t got;
        got = {x_cyc_o, x_we_o, x_adr_o, x_sel_o, x_dat_o, f_ack_o, f_err_o,
               m_ack_o, m_err_o, f_dat_o, m_dat_o};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s %0d: got cyc=%b we=%b adr=%h sel=%h dat=%h fack=%b ferr=%b mack=%b merr=%b fdat=%h | exp cyc=%b we=%b adr=%h sel=%h dat=%h fack=%b ferr=%b mack=%b merr=%b fdat=%h",
                     tag, idx, got.x_cyc, got.x_we, got.x_adr, got.x_sel, got.x_dat,
                     got.f_ack, got.f_err, got.m_ack, got.m_err, got.f_dat,
                     exp.x_cyc, exp.x_we, exp.x_adr, exp.x_sel, exp.x_dat,
                     exp.f_ack, exp.f_err, exp.m_ack, exp.m_err, exp.f_dat);
        end
    endtask

    localparam logic [63:0] FB_HI = 64'hFFFF_FFFF_FFFF_FF04;
    localparam logic [63:0] FB_LO = 64'h0000_0000_8000_1000;
    localparam logic [60:0] MA    = 61'h0ABC_DEF0_1234_5678;
    localparam logic [63:0] MD    = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] XD    = 64'h1122_3344_5566_7788;

    initial begin
        int   own, last, wcnt, cur;
        logic err, fc, mc;
        vec_t v;

        // reset behaviour, single fetch, fetch with wait states, then store
        tbl.push_back(row(1, 1, FB_HI, 1, 1, MA, 8'h3C, MD, XD, 1, 0, 0));
        tbl.push_back(row(1, 0, FB_HI, 0, 0, MA, 8'h3C, MD, XD, 0, 0, 0));
        tbl.push_back(row(0, 1, FB_HI, 0, 0, MA, 8'h3C, MD, XD, 1, 1, 0));
        tbl.push_back(row(0, 1, FB_LO, 0, 1, MA, 8'h3C, MD, XD, 0, 1, 0));
        tbl.push_back(row(0, 1, FB_LO, 1, 1, MA, 8'h3C, MD, XD, 0, 1, 0));
        tbl.push_back(row(0, 1, FB_LO, 1, 1, MA, 8'h3C, MD, XD, 0, 1, 0));
        tbl.push_back(row(0, 1, FB_LO, 1, 1, MA, 8'h3C, MD, XD, 1, 1, 0));
        tbl.push_back(row(0, 0, FB_LO, 1, 1, MA, 8'h3C, MD, XD, 1, 2, 0));
        // both requesting from reset: M, F, M, F
        tbl.push_back(row(1, 1, FB_HI, 1, 1, MA, 8'hA5, MD, XD, 1, 0, 0));
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hA5, MD, XD, 1, 2, 0));
        tbl.push_back(row(0, 1, FB_LO, 1, 1, MA, 8'hA5, MD, XD, 1, 1, 0));
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'h5A, MD, XD, 1, 2, 0));
        tbl.push_back(row(0, 1, FB_LO, 1, 1, MA, 8'h5A, MD, XD, 1, 1, 0));
        // M locked then abandoned: one idle cycle, then pending F
        tbl.push_back(row(0, 0, FB_LO, 1, 1, MA, 8'hFF, MD, XD, 0, 2, 0));
        tbl.push_back(row(0, 1, FB_LO, 0, 0, 61'd0, 8'h00, 64'd0, XD, 0, 2, 0));
        tbl.push_back(row(0, 1, FB_LO, 0, 0, 61'd0, 8'h00, 64'd0, XD, 1, 1, 0));
        tbl.push_back(row(1, 0, FB_LO, 0, 0, MA, 8'hFF, MD, XD, 0, 0, 0));
        tbl.push_back(row(0, 0, FB_LO, 1, 1, MA, 8'hFF, MD, XD, 0, 2, 0));
`ifdef BUS_TIMEOUT_EN
        // watchdog fires on the 4th wait cycle, then F wins the tie
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hFF, MD, XD, 0, 2, 0));
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hFF, MD, XD, 0, 2, 0));
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hFF, MD, XD, 0, 2, 1));
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hFF, MD, XD, 1, 1, 0));
`else
        // no watchdog: M holds the bus indefinitely
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hFF, MD, XD, 0, 2, 0));
        end
        tbl.push_back(row(0, 1, FB_HI, 1, 1, MA, 8'hFF, MD, XD, 1, 2, 0));
`endif

        drive(tbl[0]);
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check(tbl[i].exp, "table", i);
            @(posedge clk);
            #1;
        end

        // randomized traffic against the reference model
        own = 0; last = 1; wcnt = 0; fc = 0; mc = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) fc = ~fc;
            if ($urandom_range(0, 3) == 0) mc = ~mc;
            v.rst    = (i == 0) || ($urandom_range(0, 59) == 0);
            v.f_cyc  = fc;
            v.f_byte = {$urandom(), $urandom()};
            v.m_cyc  = mc;
            v.m_we   = 1'($urandom());
            v.m_adr  = 61'({$urandom(), $urandom()});
            v.m_sel  = 8'($urandom());
            v.m_dat  = {$urandom(), $urandom()};
            v.x_dat  = {$urandom(), $urandom()};
            v.x_ack  = ($urandom_range(0, 9) < 6);

            if (v.rst)                    cur = 0;
            else if (own != 0)            cur = own;
            else if (v.f_cyc && v.m_cyc)  cur = (last == 1) ? 2 : 1;
            else if (v.f_cyc)             cur = 1;
            else if (v.m_cyc)             cur = 2;
            else                          cur = 0;

            err = 1'b0;
`ifdef BUS_TIMEOUT_EN
            if (cur != 0 && ((cur == 1) ? v.f_cyc : v.m_cyc) && !v.x_ack && wcnt == int'(TMO) - 1)
                err = 1'b1;
`endif
            v.exp = model_out(v, cur, err);

            drive(v);
            @(negedge clk);
            check(v.exp, "random", i);

            if (v.rst) begin
                own = 0; last = 1; wcnt = 0;
            end else if ((v.exp.x_cyc && v.x_ack) || err) begin
                own = 0; last = cur; wcnt = 0;
            end else if (v.exp.x_cyc) begin
                own = cur; wcnt++;
            end else begin
                own = 0; wcnt = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
